// File: rtl/fir_stream_mac.sv
// ============================================================================
// fir_stream_mac : streaming FIR with runtime coefficient RAM and a single
//                  time-multiplexed MAC. Define FIR_SAT_EN to saturate the
//                  output narrowing instead of wrapping.
// Revision 1.0
// ============================================================================
`default_nettype none

module fir_stream_mac #(
  parameter int TAPS   = 8,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS),
  parameter int OUT_W  = 18,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OUT_W-1:0]         m_data,
  output logic                     busy
);

  localparam int IDX_W  = $clog2(TAPS);
  localparam int WIDE_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [COEF_W-1:0]   coef [TAPS];
  logic [DATA_W-1:0]   dl   [TAPS];
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    sum;
  logic [IDX_W-1:0]    idx;
  logic                accept;
  logic                last;
  logic                coef_wr;
  logic [WIDE_W-1:0]   scaled;
  logic [OUT_W-1:0]    narrowed;

  assign last    = (idx == IDX_W'(TAPS - 1));
  assign coef_wr = (state == IDLE) && coef_we &&
                   ({1'b0, coef_addr} < (IDX_W + 1)'(TAPS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        busy    = 1'b0;
        s_ready = !flush;
        accept  = s_valid && !flush;
        if (accept) state_nxt = MAC;
      end
      MAC:     if (last)    state_nxt = OUT;
      OUT:     if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Final sum includes the current product so the result registers on the last MAC edge
  assign sum    = acc + ACC_W'(coef[idx]) * ACC_W'(dl[idx]);
  assign scaled = WIDE_W'(sum >> SHIFT);

  always_comb begin
`ifdef FIR_SAT_EN
    narrowed = ((scaled >> OUT_W) != '0) ? '1 : OUT_W'(scaled);
`else
    narrowed = OUT_W'(scaled);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
    end else if (coef_wr) begin
      coef[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) dl[k] <= '0;
      acc     <= '0;
      idx     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush) begin
            for (int k = 0; k < TAPS; k++) dl[k] <= '0;
          end else if (accept) begin
            dl[0] <= s_data;
            for (int k = 1; k < TAPS; k++) dl[k] <= dl[k-1];
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= sum;
          if (last) begin
            m_data  <= narrowed;
            m_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        OUT: if (m_ready) m_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fir_stream_mac.sv
// Bench for fir_stream_mac: randomized and directed streams checked against a
// dot-product reference model of the filter.
`timescale 1ns/1ps
`default_nettype none

module tb_fir_stream_mac;

  localparam int TAPS   = 8;
  localparam int DATA_W = 8;
  localparam int COEF_W = 8;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              coef_we = 1'b0;
  logic [2:0]        coef_addr = '0;
  logic [COEF_W-1:0] coef_data = '0;
  logic              flush = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [OUT_W-1:0]  m_data;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int mcoef [TAPS];
  int mdl   [TAPS];

  fir_stream_mac #(
    .TAPS(TAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_data(coef_data), .flush(flush), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int model_out();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(mcoef[k]) * longint'(mdl[k]);
    s = s >> SHIFT;
`ifdef FIR_SAT_EN
    if (s >= (longint'(1) << OUT_W)) return (1 << OUT_W) - 1;
    return int'(s);
`else
    return int'(s % (longint'(1) << OUT_W));
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      mcoef[k] = 0;
      mdl[k]   = 0;
    end
  endtask

  task automatic write_coef(input int a, input int v);
    coef_we = 1'b1; coef_addr = 3'(a); coef_data = 8'(v);
    @(posedge clk); #1;
    coef_we = 1'b0;
    mcoef[a] = v;
  endtask

  task automatic do_flush();
    flush = 1'b1; s_valid = 1'b1; s_data = 8'($urandom);
    #1;
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_ready s_ready=%0b required 0", s_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; s_valid = 1'b0;
    for (int k = 0; k < TAPS; k++) mdl[k] = 0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_accept busy=%0b required 0", busy);
    end
  endtask

  // One sample through the full accept / MAC / OUT cycle with optional
  // same-cycle coefficient write, write-while-busy and output backpressure.
  task automatic send_sample(input int d, input int bp, input bit wr_same,
                             input int wa, input int wv, input bit wr_busy,
                             input string tag);
    int cyc;
    logic [OUT_W-1:0] expv;
    cyc = 0;
    while (s_ready !== 1'b1 && cyc < 20) begin @(posedge clk); #1; cyc++; end
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_timeout s_ready=%0b required 1", tag, s_ready);
      return;
    end
    s_valid = 1'b1; s_data = DATA_W'(d);
    if (wr_same) begin coef_we = 1'b1; coef_addr = 3'(wa); coef_data = 8'(wv); end
    @(posedge clk); #1;
    s_valid = 1'b0; coef_we = 1'b0;
    if (wr_same) mcoef[wa] = wv;
    for (int k = TAPS - 1; k > 0; k--) mdl[k] = mdl[k-1];
    mdl[0] = d;
    expv = OUT_W'(model_out());
    n_checks++;
    if (s_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL %s accept s_ready=%0b busy=%0b required 0/1", tag, s_ready, busy);
    end
    cyc = 0;
    if (wr_busy) begin
      coef_we = 1'b1; coef_addr = 3'(wa); coef_data = 8'(wv);
      @(posedge clk); #1;
      coef_we = 1'b0; cyc = 1;
    end
    m_ready = (bp == 0);
    while (m_valid !== 1'b1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
    n_checks++;
    if (cyc != TAPS || m_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s latency edges=%0d m_valid=%0b required %0d/1", tag, cyc, m_valid, TAPS);
      m_ready = 1'b0;
      return;
    end
    n_checks++;
    if (m_data !== expv) begin
      n_fail++; $display("FAIL %s m_data got=%0d required %0d", tag, m_data, expv);
    end
    if (bp > 0) begin
      s_valid = 1'b1; s_data = 8'($urandom);
      repeat (bp) begin
        @(posedge clk); #1;
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== expv || s_ready !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s stall m_valid=%0b m_data=%0d s_ready=%0b required 1/%0d/0",
                   tag, m_valid, m_data, s_ready, expv);
        end
      end
      m_ready = 1'b1;
    end
    @(posedge clk); #1;
    m_ready = 1'b0; s_valid = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0 || m_data !== expv) begin
      n_fail++;
      $display("FAIL %s handshake m_valid=%0b s_ready=%0b busy=%0b m_data=%0d required 0/1/0/%0d",
               tag, m_valid, s_ready, busy, m_data, expv);
    end
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    n_checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_init s_ready=%0b m_valid=%0b m_data=%0d busy=%0b required 1/0/0/0",
                         s_ready, m_valid, m_data, busy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < TAPS; k++) write_coef(k, 7);
    send_sample(10, 0, 0, 0, 0, 0, "reset_pre");
    s_valid = 1'b1; s_data = 8'd20;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    n_checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_data !== '0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_mac s_ready=%0b m_valid=%0b m_data=%0d busy=%0b required 1/0/0/0",
                         s_ready, m_valid, m_data, busy);
    end
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_sample(5, 0, 0, 0, 0, 0, "reset_zero_coef");
  endtask

  task automatic test_impulse();
    int c [TAPS] = '{1, 2, 3, 4, 4, 3, 2, 1};
    for (int k = 0; k < TAPS; k++) write_coef(k, c[k]);
    do_flush();
    send_sample(1, 0, 0, 0, 0, 0, "impulse");
    for (int i = 0; i < TAPS; i++) send_sample(0, 0, 0, 0, 0, 0, "impulse");
  endtask

  task automatic test_step();
    do_flush();
    for (int i = 0; i < TAPS + 1; i++) send_sample(1, 0, 0, 0, 0, 0, "step");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) send_sample(int'($urandom_range(0, 255)), 5, 0, 0, 0, 0, "backpressure");
  endtask

  task automatic test_coef_busy();
    send_sample(7, 0, 0, 0, 9, 1, "coef_busy");
    do_flush();
    send_sample(2, 0, 0, 0, 0, 0, "coef_after_flush");
    send_sample(3, 0, 1, 0, 5, 0, "coef_same_cycle");
  endtask

  task automatic test_overflow();
    for (int k = 0; k < TAPS; k++) write_coef(k, 255);
    for (int i = 0; i < TAPS; i++) send_sample(255, 0, 0, 0, 0, 0, "overflow");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 9) == 0) do_flush();
      send_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 255)),
                  bit'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_step();
    test_back_to_back();
    test_coef_busy();
    test_overflow();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
